// File: rtl/router_distributor_seq_if.sv
// router_distributor_seq_if: buffer-side request/data bundle and cell-side outputs of the
// sequential cell distributor.
interface router_distributor_seq_if #(
    parameter int NUM_BUF  = 7,
    parameter int NUM_CELL = 16,
    parameter int ADDR_W   = 4
);
    logic [NUM_BUF-1:0]        buf_req;
    logic [NUM_BUF*ADDR_W-1:0] buf_addr;
    logic [NUM_BUF-1:0]        buf_bit;
    logic [NUM_BUF-1:0]        buf_gnt;
    logic [NUM_BUF-1:0]        addr_err;
    logic [NUM_CELL-1:0]       cell_out;
    logic [NUM_CELL-1:0]       cell_busy;
    modport master (output buf_req, buf_addr, buf_bit, input buf_gnt, addr_err, cell_out, cell_busy);
    modport slave  (input buf_req, buf_addr, buf_bit, output buf_gnt, addr_err, cell_out, cell_busy);
endinterface

// File: rtl/router_distributor_seq.sv
// router_distributor_seq: claims, streams and releases cell lines for bit-serial buffers.
// Define ROUND_ROBIN_EN for per-cell rotating priority; default is lowest-index-wins.
module router_distributor_seq #(
    parameter int NUM_BUF  = 7,
    parameter int NUM_CELL = 16,
    parameter int ADDR_W   = 4
) (
    input logic clk,
    input logic rst_n,
    router_distributor_seq_if.slave bus
);
    localparam int IW = NUM_BUF > 1 ? $clog2(NUM_BUF) : 1;
    typedef logic [IW-1:0] idx_t;
    typedef enum logic {FREE, OWNED} cell_st_e;

    logic [NUM_BUF-1:0]  gnt_q, gnt_d, req_q, err_q, err_d, cand;
    logic [NUM_CELL-1:0] out_q, out_d, busy;
    cell_st_e            st_q [NUM_CELL];
    cell_st_e            st_d [NUM_CELL];
    idx_t                owner_q [NUM_CELL];
    idx_t                owner_d [NUM_CELL];
    logic                found;
    int                  win, start;
`ifdef ROUND_ROBIN_EN
    idx_t                ptr_q [NUM_CELL];
    idx_t                ptr_d [NUM_CELL];
`endif

    always_comb begin
        gnt_d   = gnt_q & bus.buf_req;
        err_d   = '0;
        out_d   = '0;
        busy    = '0;
        cand    = '0;
        st_d    = st_q;
        owner_d = owner_q;
        found   = 1'b0;
        win     = 0;
        start   = 0;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        for (int i = 0; i < NUM_BUF; i++)
            err_d[i] = bus.buf_req[i] && !req_q[i] && 32'(bus.buf_addr[i*ADDR_W +: ADDR_W]) >= NUM_CELL;
        for (int c = 0; c < NUM_CELL; c++) begin
            busy[c] = st_q[c] == OWNED;
            if (st_q[c] == OWNED) begin
                if (bus.buf_req[owner_q[c]]) out_d[c] = bus.buf_bit[owner_q[c]];
                else st_d[c] = FREE;
            end else begin
                for (int i = 0; i < NUM_BUF; i++)
                    cand[i] = bus.buf_req[i] && !gnt_q[i] && 32'(bus.buf_addr[i*ADDR_W +: ADDR_W]) == c;
                found = 1'b0;
`ifdef ROUND_ROBIN_EN
                start = int'(ptr_q[c]);
`endif
                // first pass honours the pointer, second pass wraps to index 0
                for (int i = 0; i < NUM_BUF; i++)
                    if (!found && cand[i] && i >= start) begin found = 1'b1; win = i; end
                for (int i = 0; i < NUM_BUF; i++)
                    if (!found && cand[i]) begin found = 1'b1; win = i; end
                if (found) begin
                    st_d[c]    = OWNED;
                    owner_d[c] = idx_t'(win);
                    gnt_d[win] = 1'b1;
`ifdef ROUND_ROBIN_EN
                    ptr_d[c]   = win + 1 == NUM_BUF ? '0 : idx_t'(win + 1);
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            req_q   <= '0;
            err_q   <= '0;
            out_q   <= '0;
            st_q    <= '{default: FREE};
            owner_q <= '{default: '0};
`ifdef ROUND_ROBIN_EN
            ptr_q   <= '{default: '0};
`endif
        end else begin
            gnt_q   <= gnt_d;
            req_q   <= bus.buf_req;
            err_q   <= err_d;
            out_q   <= out_d;
            st_q    <= st_d;
            owner_q <= owner_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.buf_gnt   = gnt_q;
    assign bus.addr_err  = err_q;
    assign bus.cell_out  = out_q;
    assign bus.cell_busy = busy;
endmodule

// File: tb/tb_router_distributor_seq.sv
// tb_router_distributor_seq: directed checks of grant, streaming, release, contention,
// address error and async reset for the cell distributor (NUM_CELL=12).
module tb_router_distributor_seq;
    localparam int NB = 7;
    localparam int NC = 12;
    localparam int AW = 4;

    logic clk;
    logic rst_n;
    int total = 0;
    int bad = 0;

    router_distributor_seq_if #(.NUM_BUF(NB), .NUM_CELL(NC), .ADDR_W(AW)) bus ();
    router_distributor_seq #(.NUM_BUF(NB), .NUM_CELL(NC), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.buf_addr[i*AW +: AW] = a;
    endtask

    task automatic idle();
        bus.buf_req = '0;
        bus.buf_bit = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.buf_req = '0; bus.buf_addr = '0; bus.buf_bit = '0;
        tick(); tick();
        total++; if (bus.buf_gnt !== 7'h0) begin bad++; $display("FAIL reset_gnt: got %h want 0", bus.buf_gnt); end
        total++; if (bus.cell_busy !== 12'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", bus.cell_busy); end
        total++; if (bus.cell_out !== 12'h0) begin bad++; $display("FAIL reset_out: got %h want 0", bus.cell_out); end
        total++; if (bus.addr_err !== 7'h0) begin bad++; $display("FAIL reset_err: got %h want 0", bus.addr_err); end
        rst_n = 1'b1;
        tick();
        bus.buf_req = 7'($urandom) | 7'h01;
        bus.buf_addr = 28'($urandom);
        set_addr(0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            bus.buf_bit = 7'($urandom) | 7'h01;
            tick();
        end
        total++; if (bus.buf_gnt[0] !== 1'b1 || bus.cell_busy[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_active: got gnt=%h busy=%h want gnt0=1 busy0=1", bus.buf_gnt, bus.cell_busy); end
        total++; if (bus.cell_out[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_out: got %b want 1", bus.cell_out[0]); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.buf_gnt !== 7'h0) begin bad++; $display("FAIL async_gnt: got %h want 0", bus.buf_gnt); end
        total++; if (bus.cell_busy !== 12'h0) begin bad++; $display("FAIL async_busy: got %h want 0", bus.cell_busy); end
        total++; if (bus.cell_out !== 12'h0) begin bad++; $display("FAIL async_out: got %h want 0", bus.cell_out); end
        total++; if (bus.addr_err !== 7'h0) begin bad++; $display("FAIL async_err: got %h want 0", bus.addr_err); end
        bus.buf_req = '0; bus.buf_bit = '0; bus.buf_addr = '0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] bits = 4'b1101;
        set_addr(0, 4'd5);
        bus.buf_req[0] = 1'b1;
        tick();
        total++; if (bus.buf_gnt !== 7'h01) begin bad++; $display("FAIL single_gnt: got %h want 01", bus.buf_gnt); end
        total++; if (bus.cell_busy !== 12'h020) begin bad++; $display("FAIL single_busy: got %h want 020", bus.cell_busy); end
        for (int k = 3; k >= 0; k--) begin
            bus.buf_bit[0] = bits[k];
            tick();
            total++; if (bus.cell_out !== (12'(bits[k]) << 5)) begin bad++; $display("FAIL single_bit%0d: got %h want %h", 3 - k, bus.cell_out, 12'(bits[k]) << 5); end
        end
        bus.buf_req[0] = 1'b0;
        tick();
        total++; if (bus.buf_gnt !== 7'h0 || bus.cell_busy !== 12'h0 || bus.cell_out !== 12'h0) begin bad++; $display("FAIL single_release: got gnt=%h busy=%h out=%h want 0 0 0", bus.buf_gnt, bus.cell_busy, bus.cell_out); end
        idle();
    endtask

    task automatic burst(output int order, output int cnt);
        int multi = 0;
        order = 0;
        cnt = 0;
        set_addr(2, 4'd3); set_addr(4, 4'd3); set_addr(6, 4'd3);
        bus.buf_req = 7'b1010100;
        for (int t = 0; t < 40 && cnt < 3; t++) begin
            tick();
            if ($countones(bus.buf_gnt) > 1) multi++;
            for (int k = 0; k < NB; k++)
                if (bus.buf_gnt[k] && bus.buf_req[k]) begin
                    order = order * 10 + k;
                    cnt++;
                    bus.buf_req[k] = 1'b0;
                end
        end
        if (multi != 0) cnt = -1;
        idle();
    endtask

    task automatic test_contention();
        int order, cnt;
        burst(order, cnt);
        total++; if (cnt !== 3 || order !== 246) begin bad++; $display("FAIL contention_1: got order=%0d grants=%0d want 246 3", order, cnt); end
        burst(order, cnt);
        total++; if (cnt !== 3 || order !== 246) begin bad++; $display("FAIL contention_2: got order=%0d grants=%0d want 246 3", order, cnt); end
        set_addr(4, 4'd3);
        bus.buf_req[4] = 1'b1;
        tick();
        total++; if (bus.buf_gnt !== 7'h10) begin bad++; $display("FAIL contention_solo: got %h want 10", bus.buf_gnt); end
        idle();
        burst(order, cnt);
`ifdef ROUND_ROBIN_EN
        total++; if (cnt !== 3 || order !== 624) begin bad++; $display("FAIL contention_ptr5: got order=%0d grants=%0d want 624 3", order, cnt); end
`else
        total++; if (cnt !== 3 || order !== 246) begin bad++; $display("FAIL contention_3: got order=%0d grants=%0d want 246 3", order, cnt); end
`endif
    endtask

    task automatic test_parallel();
        logic [6:0] pats [4] = '{7'h55, 7'h2A, 7'h7F, 7'h13};
        for (int i = 0; i < NB; i++) set_addr(i, 4'(i));
        bus.buf_req = 7'h7F;
        tick();
        total++; if (bus.buf_gnt !== 7'h7F) begin bad++; $display("FAIL parallel_gnt: got %h want 7f", bus.buf_gnt); end
        total++; if (bus.cell_busy !== 12'h07F) begin bad++; $display("FAIL parallel_busy: got %h want 07f", bus.cell_busy); end
        for (int k = 0; k < 4; k++) begin
            bus.buf_bit = pats[k];
            tick();
            total++; if (bus.cell_out !== {5'b0, pats[k]}) begin bad++; $display("FAIL parallel_data%0d: got %h want %h", k, bus.cell_out, {5'b0, pats[k]}); end
        end
        bus.buf_req = '0;
        tick();
        total++; if (bus.buf_gnt !== 7'h0 || bus.cell_busy !== 12'h0 || bus.cell_out !== 12'h0) begin bad++; $display("FAIL parallel_release: got gnt=%h busy=%h out=%h want 0 0 0", bus.buf_gnt, bus.cell_busy, bus.cell_out); end
        idle();
    endtask

    task automatic test_addr();
        set_addr(1, 4'd14);
        bus.buf_req[1] = 1'b1;
        tick();
        total++; if (bus.addr_err !== 7'h02 || bus.buf_gnt !== 7'h0) begin bad++; $display("FAIL addr14_err: got err=%h gnt=%h want 02 00", bus.addr_err, bus.buf_gnt); end
        tick();
        total++; if (bus.addr_err !== 7'h0 || bus.buf_gnt !== 7'h0 || bus.cell_busy !== 12'h0) begin bad++; $display("FAIL addr14_hold: got err=%h gnt=%h busy=%h want 0 0 0", bus.addr_err, bus.buf_gnt, bus.cell_busy); end
        bus.buf_req[1] = 1'b0;
        tick();
        set_addr(1, 4'd12);
        bus.buf_req[1] = 1'b1;
        tick();
        total++; if (bus.addr_err !== 7'h02 || bus.buf_gnt !== 7'h0) begin bad++; $display("FAIL addr12_err: got err=%h gnt=%h want 02 00", bus.addr_err, bus.buf_gnt); end
        bus.buf_req[1] = 1'b0;
        tick();
        set_addr(1, 4'd11);
        bus.buf_req[1] = 1'b1;
        tick();
        total++; if (bus.addr_err !== 7'h0 || bus.buf_gnt !== 7'h02 || bus.cell_busy !== 12'h800) begin bad++; $display("FAIL addr11_gnt: got err=%h gnt=%h busy=%h want 00 02 800", bus.addr_err, bus.buf_gnt, bus.cell_busy); end
        idle();
        set_addr(3, 4'd7);
        bus.buf_req[3] = 1'b1;
        tick();
        bus.buf_bit[3] = 1'b1;
        set_addr(3, 4'd8);
        tick();
        total++; if (bus.cell_out !== 12'h080 || bus.cell_busy !== 12'h080) begin bad++; $display("FAIL latch_1: got out=%h busy=%h want 080 080", bus.cell_out, bus.cell_busy); end
        bus.buf_bit[3] = 1'b0;
        tick();
        total++; if (bus.cell_out !== 12'h000 || bus.buf_gnt !== 7'h08) begin bad++; $display("FAIL latch_0: got out=%h gnt=%h want 000 08", bus.cell_out, bus.buf_gnt); end
        bus.buf_bit[3] = 1'b1;
        tick();
        total++; if (bus.cell_out !== 12'h080) begin bad++; $display("FAIL latch_1b: got %h want 080", bus.cell_out); end
        idle();
    endtask

    task automatic test_rerequest();
        set_addr(0, 4'd9);
        bus.buf_req[0] = 1'b1;
        tick();
        bus.buf_bit[0] = 1'b1;
        tick();
        total++; if (bus.buf_gnt !== 7'h01 || bus.cell_out !== 12'h200) begin bad++; $display("FAIL rereq_own: got gnt=%h out=%h want 01 200", bus.buf_gnt, bus.cell_out); end
        bus.buf_req[0] = 1'b0;
        set_addr(1, 4'd9);
        bus.buf_req[1] = 1'b1;
        bus.buf_bit[1] = 1'b1;
        tick();
        total++; if (bus.buf_gnt !== 7'h0 || bus.cell_busy !== 12'h0 || bus.cell_out !== 12'h0) begin bad++; $display("FAIL rereq_gap: got gnt=%h busy=%h out=%h want 0 0 0", bus.buf_gnt, bus.cell_busy, bus.cell_out); end
        tick();
        total++; if (bus.buf_gnt !== 7'h02 || bus.cell_busy !== 12'h200 || bus.cell_out !== 12'h0) begin bad++; $display("FAIL rereq_gnt: got gnt=%h busy=%h out=%h want 02 200 000", bus.buf_gnt, bus.cell_busy, bus.cell_out); end
        tick();
        total++; if (bus.cell_out !== 12'h200) begin bad++; $display("FAIL rereq_data: got %h want 200", bus.cell_out); end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_parallel();
        test_addr();
        test_rerequest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
